// File: rtl/rib_arbiter_pkg.sv
// ============================================================================
// Module      : rib_arbiter_pkg
// Description : Shared constants and FSM encoding for the RIB bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rib_arbiter_pkg;

    localparam int M_CORE_EX = 0;
    localparam int M_CORE_PC = 1;
    localparam int M_JTAG    = 2;
    localparam int M_UART    = 3;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rib_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector; the search starts at the
//               index after the pointer and wraps around.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [PW-1:0] o_idx,
    output logic          o_valid
);

    int w_dist;
    int w_best;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_best  = N;
        w_dist  = 0;
        for (int j = 0; j < N; j++) begin
            // Distance 0 is the slot right after the last winner.
            w_dist = (j + N - 1 - int'(i_ptr)) % N;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                o_idx   = PW'(j);
                o_valid = 1'b1;
            end
        end
        if (o_valid) begin
            o_gnt[o_idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rib_arbiter.sv
// ============================================================================
// Module      : rib_arbiter
// Description : Round-robin arbiter sharing the single RIB slave path between
//               core data, core fetch, JTAG and UART debug masters.
//               Optional slave-ack watchdog: define RIB_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rib_arbiter
    import rib_arbiter_pkg::*;
#(
    parameter int NUM_M   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_M-1:0]        m_req_i,
    input  logic [NUM_M-1:0]        m_we_i,
    input  logic [NUM_M*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_M*DATA_W-1:0] m_wdata_i,
    output logic [NUM_M-1:0]        m_ack_o,
    output logic [DATA_W-1:0]       m_rdata_o,
    output logic                    s_req_o,
    output logic                    s_we_o,
    output logic [ADDR_W-1:0]       s_addr_o,
    output logic [DATA_W-1:0]       s_wdata_o,
    input  logic [DATA_W-1:0]       s_rdata_i,
    input  logic                    s_ack_i,
    output logic                    hold_flag_o,
    output logic [NUM_M-1:0]        grant_o,
    output logic                    err_o
);

    localparam int PTR_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    // The watchdog counter is 8 bits wide, so the limit must fit in it.
    if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_bad_timeout
        $error("rib_arbiter: TIMEOUT must be in 1..255");
    end

    arb_state_t         r_state;
    arb_state_t         w_state_nxt;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [NUM_M-1:0]   r_grant;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;

    logic [NUM_M-1:0]   w_win_gnt;
    logic [PTR_W-1:0]   w_win_idx;
    logic               w_win_valid;
    logic               w_timeout;
    logic               w_done;

    rr_pick #(
        .N  (NUM_M),
        .PW (PTR_W)
    ) u_rr_pick (
        .i_req   (m_req_i),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_win_gnt),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

`ifdef RIB_ARB_TIMEOUT_EN
    logic [7:0] r_wdog;

    // Counts BUSY cycles without an ack; cleared while IDLE so each
    // transaction starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= 8'd0;
        end else if (r_state == ST_IDLE) begin
            r_wdog <= 8'd0;
        end else if (!s_ack_i && (r_wdog != 8'hFF)) begin
            r_wdog <= r_wdog + 8'd1;
        end
    end

    assign w_timeout = (r_state == ST_BUSY) && !s_ack_i && (r_wdog == 8'(TIMEOUT));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_done = (r_state == ST_BUSY) && (s_ack_i || w_timeout);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_win_valid) w_state_nxt = ST_BUSY;
            ST_BUSY: if (w_done)      w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    // Command is captured once on grant and stays frozen for the whole BUSY phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= PTR_W'(NUM_M - 1);
            r_grant  <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if ((r_state == ST_IDLE) && w_win_valid) begin
            r_rr_ptr <= w_win_idx;
            r_grant  <= w_win_gnt;
            r_we     <= m_we_i[w_win_idx];
            r_addr   <= m_addr_i[w_win_idx*ADDR_W +: ADDR_W];
            r_wdata  <= m_wdata_i[w_win_idx*DATA_W +: DATA_W];
        end else if (w_done) begin
            r_grant  <= '0;
        end
    end

    assign s_req_o   = (r_state == ST_BUSY);
    assign s_we_o    = r_we;
    assign s_addr_o  = r_addr;
    assign s_wdata_o = r_wdata;
    assign grant_o   = r_grant;
    assign err_o     = w_timeout;

    assign m_ack_o   = w_done ? r_grant : '0;
    assign m_rdata_o = !w_done   ? '0 :
                       w_timeout ? DATA_W'(TIMEOUT_RDATA) : s_rdata_i;

    assign hold_flag_o = (m_req_i[M_CORE_EX] & ~m_ack_o[M_CORE_EX]) |
                         (m_req_i[M_CORE_PC] & ~m_ack_o[M_CORE_PC]);

endmodule

`default_nettype wire

// File: tb/tb_rib_arbiter.sv
// ============================================================================
// Module      : tb_rib_arbiter
// Description : Directed self-checking bench for rib_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rib_arbiter;

    localparam int NUM_M  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
`ifdef RIB_ARB_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 255;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_M-1:0]        m_req_i;
    logic [NUM_M-1:0]        m_we_i;
    logic [NUM_M*ADDR_W-1:0] m_addr_i;
    logic [NUM_M*DATA_W-1:0] m_wdata_i;
    logic [NUM_M-1:0]        m_ack_o;
    logic [DATA_W-1:0]       m_rdata_o;
    logic                    s_req_o;
    logic                    s_we_o;
    logic [ADDR_W-1:0]       s_addr_o;
    logic [DATA_W-1:0]       s_wdata_o;
    logic [DATA_W-1:0]       s_rdata_i;
    logic                    s_ack_i;
    logic                    hold_flag_o;
    logic [NUM_M-1:0]        grant_o;
    logic                    err_o;

    int n_checks = 0;
    int n_errors = 0;

    rib_arbiter #(
        .NUM_M   (NUM_M),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req_i     (m_req_i),
        .m_we_i      (m_we_i),
        .m_addr_i    (m_addr_i),
        .m_wdata_i   (m_wdata_i),
        .m_ack_o     (m_ack_o),
        .m_rdata_o   (m_rdata_o),
        .s_req_o     (s_req_o),
        .s_we_o      (s_we_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_rdata_i   (s_rdata_i),
        .s_ack_i     (s_ack_i),
        .hold_flag_o (hold_flag_o),
        .grant_o     (grant_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        m_req_i   = '0;
        m_we_i    = '0;
        m_addr_i  = '0;
        m_wdata_i = '0;
        s_rdata_i = '0;
        s_ack_i   = 1'b0;
        #1;
        check("rst_s_req", 64'(s_req_o), 64'd0);
        check("rst_grant", 64'(grant_o), 64'd0);
        check("rst_m_ack", 64'(m_ack_o), 64'd0);
        check("rst_err",   64'(err_o),   64'd0);
        check("rst_addr",  64'(s_addr_o), 64'd0);
        check("rst_wdata", 64'(s_wdata_o), 64'd0);
        check("rst_we",    64'(s_we_o),  64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single read from core data port
        m_req_i         = 4'b0001;
        m_addr_i[31:0]  = 32'h1000_0004;
        #1;
        check("t1_idle_s_req", 64'(s_req_o), 64'd0);
        check("t1_hold_n",     64'(hold_flag_o), 64'd1);
        tick();
        check("t1_s_req",  64'(s_req_o), 64'd1);
        check("t1_grant",  64'(grant_o), 64'b0001);
        check("t1_addr",   64'(s_addr_o), 64'h1000_0004);
        check("t1_we",     64'(s_we_o), 64'd0);
        check("t1_no_ack", 64'(m_ack_o), 64'd0);
        check("t1_hold_n1", 64'(hold_flag_o), 64'd1);
        tick();
        s_ack_i   = 1'b1;
        s_rdata_i = 32'h1234_5678;
        #1;
        check("t1_ack",   64'(m_ack_o), 64'b0001);
        check("t1_rdata", 64'(m_rdata_o), 64'h1234_5678);
        check("t1_hold_ack", 64'(hold_flag_o), 64'd0);
        tick();
        m_req_i = '0;
        s_ack_i = 1'b0;
        #1;
        check("t1_done_s_req", 64'(s_req_o), 64'd0);
        check("t1_done_grant", 64'(grant_o), 64'd0);

        // Write from JTAG with a slow slave
        m_req_i            = 4'b0100;
        m_we_i             = 4'b0100;
        m_addr_i[64 +: 32] = 32'h2000_0010;
        m_wdata_i[64 +: 32] = 32'hCAFE_F00D;
        s_rdata_i          = 32'hFFFF_FFFF;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t3_s_req", 64'(s_req_o), 64'd1);
            check("t3_grant", 64'(grant_o), 64'b0100);
            check("t3_addr",  64'(s_addr_o), 64'h2000_0010);
            check("t3_wdata", 64'(s_wdata_o), 64'hCAFE_F00D);
            check("t3_we",    64'(s_we_o), 64'd1);
            check("t3_hold",  64'(hold_flag_o), 64'd0);
            check("t3_rdata_zero", 64'(m_rdata_o), 64'd0);
            tick();
        end
        s_ack_i = 1'b1;
        #1;
        check("t3_ack", 64'(m_ack_o), 64'b0100);
        tick();
        m_req_i = '0;
        m_we_i  = '0;
        s_ack_i = 1'b0;

        // UART master drops its request while BUSY
        m_req_i            = 4'b1000;
        m_addr_i[96 +: 32] = 32'h3000_0000;
        tick();
        m_req_i = '0;
        #1;
        check("t5_s_req", 64'(s_req_o), 64'd1);
        check("t5_grant", 64'(grant_o), 64'b1000);
        tick();
        tick();
        check("t5_still_busy", 64'(s_req_o), 64'd1);
        s_ack_i   = 1'b1;
        s_rdata_i = 32'hA5A5_0003;
        #1;
        check("t5_ack",   64'(m_ack_o), 64'b1000);
        check("t5_rdata", 64'(m_rdata_o), 64'hA5A5_0003);
        tick();
        s_ack_i = 1'b0;

        // Reset in the middle of a core fetch transaction
        m_req_i = 4'b0010;
        tick();
        check("t4_grant_pre", 64'(grant_o), 64'b0010);
        s_ack_i = 1'b1;
        rst     = 1'b1;
        #1;
        check("t4_s_req", 64'(s_req_o), 64'd0);
        check("t4_grant", 64'(grant_o), 64'd0);
        check("t4_m_ack", 64'(m_ack_o), 64'd0);
        tick();
        rst = 1'b0;

        // Fairness: all masters request, zero-wait slave
        m_req_i = 4'b1111;
        for (int i = 0; i < NUM_M; i++) begin
            m_addr_i[i*ADDR_W +: ADDR_W] = 32'h4000_0000 + 32'(i * 16);
        end
        s_rdata_i = 32'h5555_AAAA;
        s_ack_i   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("t2_idle_ack", 64'(m_ack_o), 64'd0);
            check("t2_idle_req", 64'(s_req_o), 64'd0);
            tick();
            check("t2_grant", 64'(grant_o), 64'(4'b0001 << (k % 4)));
            check("t2_ack",   64'(m_ack_o), 64'(4'b0001 << (k % 4)));
            check("t2_addr",  64'(s_addr_o), 64'(32'h4000_0000 + 32'((k % 4) * 16)));
            check("t2_rdata", 64'(m_rdata_o), 64'h5555_AAAA);
            tick();
        end
        m_req_i = '0;
        s_ack_i = 1'b0;
        tick();

`ifdef RIB_ARB_TIMEOUT_EN
        // Slave never answers: watchdog fires after TIMEOUT busy cycles
        m_req_i = 4'b0001;
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            check("t6_wait_ack", 64'(m_ack_o), 64'd0);
            check("t6_wait_err", 64'(err_o), 64'd0);
            check("t6_wait_req", 64'(s_req_o), 64'd1);
            tick();
        end
        check("t6_ack",   64'(m_ack_o), 64'b0001);
        check("t6_rdata", 64'(m_rdata_o), 64'hDEAD_BEEF);
        check("t6_err",   64'(err_o), 64'd1);
        tick();
        m_req_i = '0;
        #1;
        check("t6_idle_req", 64'(s_req_o), 64'd0);
        check("t6_idle_err", 64'(err_o), 64'd0);
        s_ack_i = 1'b1;
        #1;
        check("t6_late_ack", 64'(m_ack_o), 64'd0);
        tick();
        s_ack_i = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
